// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions: group width and group generate/propagate.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic g;
    logic p;
  } grp_gp_t;

  // Group generate/propagate of a 4-bit slice from its per-bit g/p terms.
  function automatic grp_gp_t cla_group_gp(input logic [3:0] g, input logic [3:0] p);
    grp_gp_t r;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p = &p;
    return r;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: internal carries plus group generate/propagate.
// Latency: combinational.
// Backpressure: not applicable.
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       c_in,
  output logic [3:1] c,
  output logic       grp_g,
  output logic       grp_p
);

  grp_gp_t gp;

  // Every internal carry is expanded in two levels so no carry waits on its neighbour.
  always_comb begin
    gp    = cla_group_gp(g, p);
    grp_g = gp.g;
    grp_p = gp.p;
    c[1]  = g[0] | (p[0] & c_in);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder (g/p capture, then group carry resolve + sum).
// Latency: 2 cycles accept-to-out_valid; 1 beat/cycle throughput.
// Backpressure: holds up to 2 beats under out_ready=0; in_ready drops when both stages are full.
// Optional: CLA_OVF_FLAG_EN adds a registered signed-overflow output.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef CLA_OVF_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int NGRP = WIDTH / CLA_GROUP;

  if ((WIDTH % CLA_GROUP) != 0 || WIDTH < CLA_GROUP) begin : g_bad_width
    $fatal(1, "cla_pipe_adder: WIDTH=%0d must be a non-zero multiple of 4", WIDTH);
  end
  if (GROUP != CLA_GROUP) begin : g_bad_group
    $fatal(1, "cla_pipe_adder: GROUP=%0d is fixed at 4", GROUP);
  end

  // Stage 1 state.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic             s1_cin;
`ifdef CLA_OVF_FLAG_EN
  logic             s1_a_msb;
  logic             s1_b_msb;
  logic             nxt_ovf;
`endif

  // Stage 2 state; the output registers are the stage-2 data registers.
  logic             s2_valid;
  logic             s1_load;
  logic             s2_load;

  // Stage 2 combinational carry network.
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_cin;
  logic             nxt_cout;
  logic [WIDTH-1:0] nxt_sum;

  // Handshake: a stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    s2_load   = s1_valid & (~s2_valid | out_ready);
    in_ready  = ~s1_valid | s2_load;
    s1_load   = in_valid & in_ready;
    out_valid = s2_valid;
  end

  // Pipeline occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= s1_load | (s1_valid & ~s2_load);
      s2_valid <= s2_load | (s2_valid & ~out_ready);
    end
  end

  // Stage 1: capture per-bit generate/propagate and carry-in of an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_g   <= '0;
      s1_p   <= '0;
      s1_cin <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
`endif
    end else if (s1_load) begin
      s1_g   <= a & b;
      s1_p   <= a ^ b;
      s1_cin <= c_in;
`ifdef CLA_OVF_FLAG_EN
      s1_a_msb <= a[WIDTH-1];
      s1_b_msb <= b[WIDTH-1];
`endif
    end
  end

  // One lookahead unit per 4-bit slice; its entry carry comes from the group chain.
  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    logic [3:1] cc;

    cla_group4 u_grp (
      .g     (s1_g[4*k +: 4]),
      .p     (s1_p[4*k +: 4]),
      .c_in  (grp_cin[k]),
      .c     (cc),
      .grp_g (grp_g[k]),
      .grp_p (grp_p[k])
    );

    assign nxt_sum[4*k +: 4] = s1_p[4*k +: 4] ^ {cc, grp_cin[k]};
  end

  // Inter-group carry chain; group G/P do not depend on the entry carry, so no loop.
  always_comb begin
    logic cc_run;
    cc_run  = s1_cin;
    grp_cin = '0;
    for (int k = 0; k < NGRP; k++) begin
      grp_cin[k] = cc_run;
      cc_run     = grp_g[k] | (grp_p[k] & cc_run);
    end
    nxt_cout = cc_run;
  end

`ifdef CLA_OVF_FLAG_EN
  // Signed overflow: like-signed operands producing a result of the other sign.
  always_comb begin
    nxt_ovf = (s1_a_msb == s1_b_msb) & (nxt_sum[WIDTH-1] != s1_a_msb);
  end
`endif

  // Stage 2: register the resolved result; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
      overflow <= 1'b0;
`endif
    end else if (s2_load) begin
      sum   <= nxt_sum;
      c_out <= nxt_cout;
`ifdef CLA_OVF_FLAG_EN
      overflow <= nxt_ovf;
`endif
    end
  end

endmodule
